// File: rtl/beamformer_controller.sv
`default_nettype none
// ============================================================================
// Module      : beamformer_controller
// Description : Run sequencer for the BRAM delay-and-sum beamformer: load
//               wait, 4-phase slice stepping, sum tracking and result drain.
// Revision    : 1.0 - initial release
// ============================================================================
module beamformer_controller #(
  parameter int ADDR_W     = 11,
  parameter int SAMPLE_W   = 16,
  parameter int DATA_W     = 12,
  parameter int NUM_IN     = 2048,
  parameter int NUM_OUT    = 2048,
  parameter int LOAD_DELAY = 10,
  parameter int READ_LAT   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                usedataflag,
  input  logic [DATA_W-1:0]   output_value,
  input  logic                out_ready,
  output logic [ADDR_W-1:0]   readin_address,
  output logic [ADDR_W-1:0]   sumout_address,
  output logic [SAMPLE_W-1:0] sample_index,
  output logic                startbeamformer,
  output logic                readinen,
  output logic                sumouten,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  output logic                busy,
  output logic                done
);

  localparam int C_LOAD_CW = $clog2(LOAD_DELAY + 1);
  localparam int C_LAT_CW  = $clog2(READ_LAT + 1);

  localparam logic [ADDR_W-1:0]    C_LAST_IN   = ADDR_W'(NUM_IN - 1);
  localparam logic [ADDR_W-1:0]    C_LAST_OUT  = ADDR_W'(NUM_OUT - 1);
  localparam logic [C_LOAD_CW-1:0] C_LOAD_LAST = C_LOAD_CW'(LOAD_DELAY - 1);
  localparam logic [C_LAT_CW-1:0]  C_LAT_LAST  = C_LAT_CW'(READ_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ACCUM = 3'd2,
    S_DRAIN = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t               r_state;
  logic [1:0]           r_phase;
  logic [C_LOAD_CW-1:0] r_load_cnt;
  logic [C_LAT_CW-1:0]  r_lat_cnt;
  logic                 r_flag_q;
  logic                 w_flag_fall;

  // Raw flag against its one-cycle-old copy: falling edge seen without extra delay.
  assign w_flag_fall = r_flag_q & ~usedataflag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_phase         <= 2'd0;
      r_load_cnt      <= '0;
      r_lat_cnt       <= '0;
      r_flag_q        <= 1'b0;
      readin_address  <= '0;
      sumout_address  <= '0;
      sample_index    <= '1;
      startbeamformer <= 1'b0;
      readinen        <= 1'b0;
      sumouten        <= 1'b0;
      out_data        <= '0;
      out_valid       <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      r_flag_q <= usedataflag;
      done     <= 1'b0;
      if (abort) begin
        r_state         <= S_IDLE;
        startbeamformer <= 1'b0;
        readinen        <= 1'b0;
        sumouten        <= 1'b0;
        out_valid       <= 1'b0;
        busy            <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            readin_address <= '0;
            sumout_address <= '0;
            sample_index   <= '1;
            if (start) begin
              r_state    <= S_LOAD;
              r_load_cnt <= '0;
              busy       <= 1'b1;
            end
          end
          S_LOAD: begin
            if (r_load_cnt == C_LOAD_LAST) begin
              r_state         <= S_ACCUM;
              r_phase         <= 2'd0;
              startbeamformer <= 1'b1;
            end else begin
              r_load_cnt <= r_load_cnt + 1'b1;
            end
          end
          S_ACCUM: begin
            r_phase <= r_phase + 2'd1;
            if (w_flag_fall)
              sumout_address <= sumout_address + 1'b1;
            case (r_phase)
              2'd0: readinen <= 1'b0;
              2'd1: begin
                readinen     <= 1'b1;
                sample_index <= sample_index + 1'b1;
              end
              2'd2: sample_index <= sample_index + 1'b1;
              2'd3: begin
                sample_index <= sample_index + 1'b1;
                if (readin_address == C_LAST_IN) begin
                  // Drain restarts the output walk from address 0.
                  readin_address  <= '0;
                  r_state         <= S_DRAIN;
                  startbeamformer <= 1'b0;
                  readinen        <= 1'b0;
                  sumouten        <= 1'b1;
                  sumout_address  <= '0;
                  r_lat_cnt       <= '0;
                end else begin
                  readin_address <= readin_address + 1'b1;
                end
              end
            endcase
          end
          S_DRAIN: begin
            if (!out_valid) begin
              if (r_lat_cnt == C_LAT_LAST) begin
                out_data  <= output_value;
                out_valid <= 1'b1;
                r_lat_cnt <= '0;
              end else begin
                r_lat_cnt <= r_lat_cnt + 1'b1;
              end
            end else if (out_ready) begin
              out_valid <= 1'b0;
              if (sumout_address == C_LAST_OUT) begin
                r_state  <= S_FIN;
                done     <= 1'b1;
                sumouten <= 1'b0;
              end else begin
                sumout_address <= sumout_address + 1'b1;
              end
            end
          end
          S_FIN: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
